// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C bus-condition generator.
package i2c_pkg;

  typedef enum logic [2:0] {
    k_idle,
    k_st1,
    k_st2,
    k_st3,
    k_rs1,
    k_sp1,
    k_sp2,
    k_sp3
  } state_e;

  localparam logic [1:0] k_cmd_start  = 2'b00;
  localparam logic [1:0] k_cmd_rstart = 2'b01;
  localparam logic [1:0] k_cmd_stop   = 2'b10;

  localparam logic k_release  = 1'b1;
  localparam logic k_drive_lo = 1'b0;

  // Open-drain levels {scl, sda} driven while sitting in a given state.
  function automatic logic [1:0] line_levels(input state_e s);
    logic [1:0] lv;
    case (s)
      k_st2:   lv = {k_release,  k_drive_lo};
      k_st3:   lv = {k_drive_lo, k_drive_lo};
      k_rs1:   lv = {k_drive_lo, k_release};
      k_sp1:   lv = {k_drive_lo, k_drive_lo};
      k_sp2:   lv = {k_release,  k_drive_lo};
      default: lv = {k_release,  k_release};
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Phase counter: counts 0..div_q per phase, held at zero while SCL is stretched.
module i2c_phase_timer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 run_i,
  input  logic                 hold_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 phase_end_o
);

  logic [DIV_WIDTH-1:0] ctr_q;
  logic [DIV_WIDTH-1:0] div_q;

  assign phase_end_o = run_i && !hold_i && (ctr_q == div_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_q <= '0;
      div_q <= '0;
    end else if (load_i) begin
      ctr_q <= '0;
      div_q <= div_i;
    end else if (run_i) begin
      if (hold_i || phase_end_o) begin
        ctr_q <= '0;
      end else begin
        ctr_q <= ctr_q + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_cond_gen.sv
// I2C START / repeated START / STOP generator with clock-stretch and
// arbitration-loss handling; all outputs are registered.
module i2c_cond_gen
  import i2c_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid_i,
  input  logic [1:0]           cmd_i,
  output logic                 cmd_ready_o,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  input  logic                 scl_in_i,
  input  logic                 sda_in_i,
  output logic                 scl_out_o,
  output logic                 sda_out_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 bus_busy_o,
  output logic                 stretching_o
);

  state_e state_q, state_d;
  logic   scl_out_q, sda_out_q, cmd_ready_q;
  logic   done_q, done_d, err_q, err_d;
  logic   bus_busy_q, bus_busy_d, stretching_q;
  logic   accept, hold, phase_end, arb_lost;

  assign accept   = cmd_valid_i && cmd_ready_q;
  assign hold     = (state_q != k_idle) && scl_out_q && !scl_in_i;
  assign arb_lost = ((state_q == k_st1) || (state_q == k_sp3)) && !sda_in_i && phase_end;

  i2c_phase_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .load_i      (accept),
    .run_i       (state_q != k_idle),
    .hold_i      (hold),
    .div_i       (divisor_i),
    .phase_end_o (phase_end)
  );

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    bus_busy_d = bus_busy_q;
    case (state_q)
      k_idle: begin
        if (accept) begin
          case (cmd_i)
            k_cmd_start:  state_d = k_st1;
            k_cmd_rstart: state_d = k_rs1;
            k_cmd_stop:   state_d = k_sp1;
            default: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          endcase
        end
      end
      default: begin
        // Losing SDA while we release it means another master owns the bus.
        if (arb_lost) begin
          state_d    = k_idle;
          done_d     = 1'b1;
          err_d      = 1'b1;
          bus_busy_d = 1'b0;
        end else if (phase_end) begin
          case (state_q)
            k_st1: state_d = k_st2;
            k_st2: state_d = k_st3;
            k_st3: begin
              state_d    = k_idle;
              done_d     = 1'b1;
              bus_busy_d = 1'b1;
            end
            k_rs1: state_d = k_st1;
            k_sp1: state_d = k_sp2;
            k_sp2: state_d = k_sp3;
            k_sp3: begin
              state_d    = k_idle;
              done_d     = 1'b1;
              bus_busy_d = 1'b0;
            end
            default: state_d = k_idle;
          endcase
        end
      end
    endcase
  end

  // Line levels and ready follow the state being entered, so they change on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= k_idle;
      scl_out_q    <= k_release;
      sda_out_q    <= k_release;
      cmd_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      bus_busy_q   <= 1'b0;
      stretching_q <= 1'b0;
    end else begin
      state_q                <= state_d;
      {scl_out_q, sda_out_q} <= line_levels(state_d);
      cmd_ready_q            <= (state_d == k_idle);
      done_q                 <= done_d;
      err_q                  <= err_d;
      bus_busy_q             <= bus_busy_d;
      stretching_q           <= hold;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign scl_out_o    = scl_out_q;
  assign sda_out_o    = sda_out_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign bus_busy_o   = bus_busy_q;
  assign stretching_o = stretching_q;

endmodule

// File: tb/tb_i2c_cond_gen.sv
// Self-checking bench: a phase-list model of the bus conditions runs beside
// the DUT and is compared every cycle, plus directed literal checks.
module tb_i2c_cond_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmdValid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [15:0] divisor = 16'd0;
  logic        sclForce = 1'b0;
  logic        sdaForce = 1'b0;
  logic        cmdReady, sclOut, sdaOut, doneOut, errOut, busyOut, stretchOut;
  logic        sclIn, sdaIn;

  int assertCount = 0;
  int failCount = 0;
  int stretchCount = 0;
  int cyc;
  bit cmpEn = 1'b0;
  logic [1:0] lineTrace [0:63];

  always #5 clk = ~clk;

  // Wired-AND bus: another device can only pull a line low.
  assign sclIn = sclOut & ~sclForce;
  assign sdaIn = sdaOut & ~sdaForce;

  i2c_cond_gen #(.DIV_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid_i  (cmdValid),
    .cmd_i        (cmd),
    .cmd_ready_o  (cmdReady),
    .divisor_i    (divisor),
    .scl_in_i     (sclIn),
    .sda_in_i     (sdaIn),
    .scl_out_o    (sclOut),
    .sda_out_o    (sdaOut),
    .done_o       (doneOut),
    .err_o        (errOut),
    .bus_busy_o   (busyOut),
    .stretching_o (stretchOut)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a condition is a list of phases {scl, sda, length, arbitration-checked}.
  typedef struct {
    logic scl;
    logic sda;
    int   len;
    bit   arb;
  } phase_t;

  phase_t mQ[$];
  int     mUsed = 0;
  int     mLen;
  bit     mEndBusy = 1'b0;
  bit     mHeld;
  logic   expScl = 1'b1, expSda = 1'b1, expDone = 1'b0, expErr = 1'b0;
  logic   expBusy = 1'b0, expReady = 1'b1, expStretch = 1'b0;

  function automatic phase_t ph(input logic s, input logic a, input int l, input bit r);
    phase_t p;
    p.scl = s;
    p.sda = a;
    p.len = l;
    p.arb = r;
    return p;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mQ.delete();
      mUsed = 0;
      {expScl, expSda, expDone, expErr} = 4'b1100;
      {expBusy, expReady, expStretch} = 3'b010;
    end else begin
      expDone = 1'b0;
      expErr = 1'b0;
      if (mQ.size() == 0) begin
        expStretch = 1'b0;
        if (cmdValid) begin
          mLen = int'(divisor) + 1;
          case (cmd)
            2'b00: begin
              mQ.push_back(ph(1'b1, 1'b1, mLen, 1'b1));
              mQ.push_back(ph(1'b1, 1'b0, mLen, 1'b0));
              mQ.push_back(ph(1'b0, 1'b0, mLen, 1'b0));
              mEndBusy = 1'b1;
            end
            2'b01: begin
              mQ.push_back(ph(1'b0, 1'b1, mLen, 1'b0));
              mQ.push_back(ph(1'b1, 1'b1, mLen, 1'b1));
              mQ.push_back(ph(1'b1, 1'b0, mLen, 1'b0));
              mQ.push_back(ph(1'b0, 1'b0, mLen, 1'b0));
              mEndBusy = 1'b1;
            end
            2'b10: begin
              mQ.push_back(ph(1'b0, 1'b0, mLen, 1'b0));
              mQ.push_back(ph(1'b1, 1'b0, mLen, 1'b0));
              mQ.push_back(ph(1'b1, 1'b1, mLen, 1'b1));
              mEndBusy = 1'b0;
            end
            default: begin
              expDone = 1'b1;
              expErr = 1'b1;
            end
          endcase
          if (mQ.size() > 0) begin
            expScl = mQ[0].scl;
            expSda = mQ[0].sda;
            expReady = 1'b0;
            mUsed = 0;
          end
        end
      end else begin
        mHeld = mQ[0].scl && sclForce;
        expStretch = mHeld;
        if (mHeld) begin
          mUsed = 0;
        end else if (mUsed == mQ[0].len - 1) begin
          if (mQ[0].arb && sdaForce) begin
            mQ.delete();
            {expScl, expSda, expDone, expErr, expBusy, expReady} = 6'b111101;
          end else begin
            void'(mQ.pop_front());
            mUsed = 0;
            if (mQ.size() == 0) begin
              {expScl, expSda, expDone, expReady} = 4'b1111;
              expBusy = mEndBusy;
            end else begin
              expScl = mQ[0].scl;
              expSda = mQ[0].sda;
            end
          end
        end else begin
          mUsed++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("scl_out", sclOut, expScl);
      checkOutput("sda_out", sdaOut, expSda);
      checkOutput("done", doneOut, expDone);
      checkOutput("err", errOut, expErr);
      checkOutput("bus_busy", busyOut, expBusy);
      checkOutput("cmd_ready", cmdReady, expReady);
      checkOutput("stretching", stretchOut, expStretch);
    end
    if (stretchOut) stretchCount++;
  end

  // Present a command for exactly one accepting edge, then scramble the divisor.
  task automatic applyStimulus(input logic [1:0] c, input logic [15:0] d);
    cmdValid = 1'b1;
    cmd = c;
    divisor = d;
    @(posedge clk);
    #2;
    cmdValid = 1'b0;
    divisor = 16'h5A5A;
  endtask

  task automatic waitDone(input int limit, output int doneCyc);
    doneCyc = 0;
    for (int i = 1; i <= limit && doneCyc == 0; i++) begin
      @(negedge clk);
      if (i < 64) lineTrace[i] = {sclOut, sdaOut};
      if (doneOut) doneCyc = i;
    end
    if (doneCyc == 0) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    @(posedge clk);
    #2;
    cmpEn = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready", cmdReady, 1);
    checkOutput("reset_lines", {sclOut, sdaOut}, 2'b11);
    checkOutput("reset_busy", busyOut, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // START, divisor 3, with an ignored STOP request mid-condition
    applyStimulus(2'b00, 16'd3);
    fork
      begin
        @(posedge clk);
        #2;
        cmdValid = 1'b1;
        cmd = 2'b10;
        @(posedge clk);
        #2;
        cmdValid = 1'b0;
      end
      waitDone(200, cyc);
    join
    checkOutput("start_done_cycle", cyc, 13);
    checkOutput("start_err", errOut, 0);
    checkOutput("start_busy", busyOut, 1);
    checkOutput("start_ready", cmdReady, 1);
    checkOutput("start_lines_c4", lineTrace[4], 2'b11);
    checkOutput("start_lines_c5", lineTrace[5], 2'b10);
    checkOutput("start_lines_c9", lineTrace[9], 2'b00);
    checkOutput("start_lines_c12", lineTrace[12], 2'b00);

    // STOP, divisor 0, issued in the done cycle with no bubble
    applyStimulus(2'b10, 16'd0);
    waitDone(200, cyc);
    checkOutput("stop_done_cycle", cyc, 4);
    checkOutput("stop_busy", busyOut, 0);
    checkOutput("stop_lines_c1", lineTrace[1], 2'b00);
    checkOutput("stop_lines_c2", lineTrace[2], 2'b10);

    // RSTART, divisor 1, SCL held low 5 cycles at the start of ST1
    stretchCount = 0;
    applyStimulus(2'b01, 16'd1);
    fork
      begin
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        sclForce = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        sclForce = 1'b0;
      end
      waitDone(200, cyc);
    join
    checkOutput("rstart_done_cycle", cyc, 14);
    checkOutput("rstart_stretch_cycles", stretchCount, 5);
    checkOutput("rstart_busy", busyOut, 1);
    checkOutput("rstart_lines_c1", lineTrace[1], 2'b01);

    // Arbitration loss: SDA pulled low through ST1 while the bus is busy
    sdaForce = 1'b1;
    applyStimulus(2'b00, 16'd2);
    waitDone(200, cyc);
    sdaForce = 1'b0;
    checkOutput("arb_done_cycle", cyc, 4);
    checkOutput("arb_err", errOut, 1);
    checkOutput("arb_busy", busyOut, 0);
    checkOutput("arb_lines_c2", lineTrace[2], 2'b11);
    checkOutput("arb_lines_c4", lineTrace[4], 2'b11);

    // START divisor 0, then a reserved command leaves bus_busy alone
    applyStimulus(2'b00, 16'd0);
    waitDone(200, cyc);
    checkOutput("start0_done_cycle", cyc, 4);
    applyStimulus(2'b11, 16'd7);
    waitDone(200, cyc);
    checkOutput("rsvd_done_cycle", cyc, 1);
    checkOutput("rsvd_err", errOut, 1);
    checkOutput("rsvd_busy", busyOut, 1);
    checkOutput("rsvd_lines", lineTrace[1], 2'b11);

    // Reset in the middle of SP2
    applyStimulus(2'b10, 16'd5);
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("sp2_lines", {sclOut, sdaOut}, 2'b10);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_sp2_ready", cmdReady, 1);
    checkOutput("rst_sp2_lines", {sclOut, sdaOut}, 2'b11);
    checkOutput("rst_sp2_busy", busyOut, 0);
    checkOutput("rst_sp2_done", doneOut, 0);

    // Huge divisor aborted by reset, then a fast START completes normally
    applyStimulus(2'b00, 16'hFFFF);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_ffff_ready", cmdReady, 1);
    checkOutput("rst_ffff_lines", {sclOut, sdaOut}, 2'b11);
    applyStimulus(2'b00, 16'd0);
    waitDone(200, cyc);
    checkOutput("post_rst_done_cycle", cyc, 4);

    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
